// File: rtl/kcpe_sched.sv
// kcpe_sched: sequencing controller for the 3-channel / 4-kernel MAC array.
//
// For every output pixel it walks win*grp steps. Each step fetches data and
// weights, issues them to the array together with the running partial sum,
// and waits for all kernel lanes to return a new psum. Finished pixels are
// presented on a ready/valid port. Only one step is in flight at a time, so
// the psum fed back to the array is never stale.
//
// Optional build macro:
//   KCPE_SCHED_RELU_EN - clamp negative lanes of o_out_psum to zero.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_start, i_cfg_*                job start pulse and job configuration
//   o_data_addr, o_weight_addr      buffer read addresses
//   o_rd_en                         buffer read strobe (data valid next cycle)
//   o_pe_data_val, o_pe_weight_val  operand valids to the array
//   o_pe_psum / i_pe_psum           psum to / from the array
//   i_pe_psum_val                   per-kernel psum valid from the array
//   o_out_psum, o_out_val, i_out_ready  finished pixel result handshake
//   o_busy, o_done                  status; o_done pulses once per job
//   o_err                           sticky error flags {2: start while busy,
//                                   1: psum timeout, 0: partial psum valid}
module kcpe_sched #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned NUM_KERNEL = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [7:0]                      i_cfg_win,
    input  logic [7:0]                      i_cfg_grp,
    input  logic [15:0]                     i_cfg_pix,
    input  logic [ADDR_WIDTH-1:0]           i_cfg_data_base,
    input  logic [ADDR_WIDTH-1:0]           i_cfg_pix_stride,
    output logic [ADDR_WIDTH-1:0]           o_data_addr,
    output logic [ADDR_WIDTH-1:0]           o_weight_addr,
    output logic                            o_rd_en,
    output logic                            o_pe_data_val,
    output logic                            o_pe_weight_val,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_pe_psum,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_pe_psum,
    input  logic [NUM_KERNEL-1:0]           i_pe_psum_val,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_out_psum,
    output logic                            o_out_val,
    input  logic                            i_out_ready,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [REG_WIDTH-1:0]            o_err
);

    localparam int unsigned PSUM_W = BIT_WIDTH * NUM_KERNEL;
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StOut, StDone} state_e;

    state_e                state_q;
    logic [15:0]           steps_q;
    logic [15:0]           step_cnt_q;
    logic [15:0]           pix_q;
    logic [15:0]           pix_cnt_q;
    logic [ADDR_WIDTH-1:0] pix_base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [PSUM_W-1:0]     acc_q;
    logic [WCNT_W-1:0]     wait_cnt_q;
    logic [2:0]            err_q;

    logic [15:0]           step_inc;
    logic [ADDR_WIDTH-1:0] next_pix_base;

    assign step_inc      = step_cnt_q + 16'd1;
    assign next_pix_base = pix_base_q + stride_q;
    assign o_busy        = (state_q != StIdle);
    assign o_err         = REG_WIDTH'(err_q);

    function automatic logic [PSUM_W-1:0] out_fmt(input logic [PSUM_W-1:0] v);
        logic [PSUM_W-1:0] r;
        r = v;
`ifdef KCPE_SCHED_RELU_EN
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if (v[k*BIT_WIDTH + BIT_WIDTH - 1]) r[k*BIT_WIDTH +: BIT_WIDTH] = '0;
        end
`endif
        return r;
    endfunction

    // Outputs are registered: they are loaded on the transition into the
    // state that owns them, so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            steps_q         <= '0;
            step_cnt_q      <= '0;
            pix_q           <= '0;
            pix_cnt_q       <= '0;
            pix_base_q      <= '0;
            stride_q        <= '0;
            acc_q           <= '0;
            wait_cnt_q      <= '0;
            err_q           <= '0;
            o_data_addr     <= '0;
            o_weight_addr   <= '0;
            o_rd_en         <= 1'b0;
            o_pe_data_val   <= 1'b0;
            o_pe_weight_val <= 1'b0;
            o_pe_psum       <= '0;
            o_out_psum      <= '0;
            o_out_val       <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_rd_en         <= 1'b0;
            o_pe_data_val   <= 1'b0;
            o_pe_weight_val <= 1'b0;
            o_done          <= 1'b0;

            if (i_start && state_q != StIdle) err_q[2] <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        steps_q    <= 16'(i_cfg_win) * 16'(i_cfg_grp);
                        pix_q      <= i_cfg_pix;
                        stride_q   <= i_cfg_pix_stride;
                        pix_base_q <= i_cfg_data_base;
                        pix_cnt_q  <= '0;
                        step_cnt_q <= '0;
                        if (i_cfg_win == 8'd0 || i_cfg_grp == 8'd0 || i_cfg_pix == 16'd0) begin
                            state_q <= StDone;
                            o_done  <= 1'b1;
                        end else begin
                            state_q       <= StFetch;
                            o_rd_en       <= 1'b1;
                            o_data_addr   <= i_cfg_data_base;
                            o_weight_addr <= '0;
                        end
                    end
                end
                StFetch: begin
                    state_q         <= StIssue;
                    o_pe_data_val   <= 1'b1;
                    o_pe_weight_val <= 1'b1;
                    o_pe_psum       <= (step_cnt_q == 16'd0) ? '0 : acc_q;
                    wait_cnt_q      <= '0;
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (&i_pe_psum_val) begin
                        acc_q <= i_pe_psum;
                        if (step_cnt_q == steps_q - 16'd1) begin
                            state_q    <= StOut;
                            o_out_val  <= 1'b1;
                            o_out_psum <= out_fmt(i_pe_psum);
                        end else begin
                            state_q       <= StFetch;
                            step_cnt_q    <= step_inc;
                            o_rd_en       <= 1'b1;
                            o_data_addr   <= pix_base_q + ADDR_WIDTH'(step_inc);
                            o_weight_addr <= ADDR_WIDTH'(step_inc);
                        end
                    end else begin
                        if (|i_pe_psum_val) err_q[0] <= 1'b1;
                        // TIMEOUT consecutive WAIT cycles without a full response
                        if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                            err_q[1] <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (i_out_ready) begin
                        o_out_val <= 1'b0;
                        if (pix_cnt_q == pix_q - 16'd1) begin
                            state_q <= StDone;
                            o_done  <= 1'b1;
                        end else begin
                            state_q       <= StFetch;
                            pix_cnt_q     <= pix_cnt_q + 16'd1;
                            pix_base_q    <= next_pix_base;
                            step_cnt_q    <= '0;
                            o_rd_en       <= 1'b1;
                            o_data_addr   <= next_pix_base;
                            o_weight_addr <= '0;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/kcpe_sched.md
Name: kcpe_sched

Overview:
Sequencing controller for the 3-channel/4-kernel MAC array. Walks a convolution window (window positions × channel groups) for each output pixel and issues read requests to data and weight buffers. Drives the array's data/weight valids, feeds back the running partial sum, and presents finished per-pixel results through a ready/valid output port. One step is in flight at a time, so psum feedback stays hazard-free.

Parameters:
BIT_WIDTH, 8, lane width of data/weight/psum
NUM_KERNEL, 4, kernel lanes in array
ADDR_WIDTH, 12, buffer address width
REG_WIDTH, 32, error register width
TIMEOUT, 16, max cycles waiting for array psum valid

Ports:
clk  in  1  clock
rst  in  1  reset
i_start  in  1  start pulse; accepted only in IDLE
i_cfg_win  in  8  window positions per pixel (e.g. 9 for 3x3)
i_cfg_grp  in  8  channel groups per pixel (input channels / 3)
i_cfg_pix  in  16  output pixels per job
i_cfg_data_base  in  ADDR_WIDTH  data buffer start address
i_cfg_pix_stride  in  ADDR_WIDTH  data address increment per pixel
o_data_addr  out  ADDR_WIDTH  data buffer address
o_weight_addr  out  ADDR_WIDTH  weight buffer address
o_rd_en  out  1  read strobe to both buffers; read data valid next cycle
o_pe_data_val  out  1  data valid to array
o_pe_weight_val  out  1  weight valid to array
o_pe_psum  out  BIT_WIDTH*NUM_KERNEL  psum input to array
i_pe_psum  in  BIT_WIDTH*NUM_KERNEL  psum output from array
i_pe_psum_val  in  NUM_KERNEL  per-kernel psum valid from array
o_out_psum  out  BIT_WIDTH*NUM_KERNEL  finished pixel result
o_out_val  out  1  result valid
i_out_ready  in  1  downstream ready
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse at job end
o_err  out  REG_WIDTH  sticky error flags

Behaviour:
- Reset rst, synchronous, active-high; clock clk. On reset: state IDLE, all outputs 0, counters 0, accumulator 0, o_err 0. Reset mid-job aborts immediately; no o_done is issued.
- Config is latched on an accepted i_start. steps = win*grp, computed at the config's own width with no truncation.
- IDLE: on i_start, if any of win/grp/pix is 0, go to DONE and produce no outputs. Otherwise clear pix_cnt, step_cnt and data pointer (= data_base), then go to FETCH.
- FETCH (1 cycle): o_rd_en=1, o_data_addr = pix_base + step_cnt, o_weight_addr = step_cnt; then ISSUE.
- ISSUE (1 cycle): o_pe_data_val = o_pe_weight_val = 1. o_pe_psum = 0 when step_cnt==0, else the accumulator. Clear the wait counter; then WAIT.
- WAIT: when &i_pe_psum_val is true, accumulator <= i_pe_psum.
  - If step_cnt == steps-1, go to OUT.
  - Otherwise step_cnt++ and go to FETCH.
  - If i_pe_psum_val is nonzero but not all ones, set o_err[0] and keep waiting.
  - If the wait counter reaches TIMEOUT, set o_err[1] and go to IDLE (job aborted, no o_done).
- OUT: o_out_val=1, o_out_psum = accumulator; both held stable until i_out_ready. On handshake:
  - If pix_cnt == pix-1, go to DONE.
  - Otherwise pix_cnt++, pix_base += pix_stride, step_cnt = 0, go to FETCH.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored and sets o_err[2]. o_err bits [REG_WIDTH-1:3] read 0.
- Per-step cost: 3 cycles + array latency. Addresses wrap modulo 2^ADDR_WIDTH.
- Psum is per-lane BIT_WIDTH two's complement; the controller does no arithmetic on it except the optional ReLU.

Optional Feature:
KCPE_SCHED_RELU_EN
- Defined: at OUT, each kernel lane of o_out_psum with MSB=1 outputs 0; the accumulator is unchanged.
- Undefined: raw accumulator is output.

Test Plan:
- win=9, grp=1, pix=1, array model latency 3, weights/data giving lane sums 0x05,0x0A,0x0F,0x14 -> 9 issue pulses; first o_pe_psum=0; one o_out_val with those values; o_done once; total 9*(3+3)+2 cycles ±1.
- pix=3, data_base=0x100, stride=0x10, win=1, grp=2 -> data addrs 0x100,0x101,0x110,0x111,0x120,0x121; weight addrs 0,1 repeating; 3 outputs.
- Hold i_out_ready=0 for 10 cycles at OUT -> o_out_val and o_out_psum stable; no FETCH until ready=1.
- Array returns i_pe_psum_val=4'b0111, then never 4'b1111 -> o_err[0]=1, then o_err[1]=1 after 16 cycles; state IDLE; no o_done.
- i_start mid-job -> o_err[2]=1, job unaffected; rst asserted mid-WAIT -> all outputs 0 next cycle, o_busy=0.
- With KCPE_SCHED_RELU_EN, accumulated lanes 0xF0,0x10,0x80,0x7F -> o_out_psum lanes 0x00,0x10,0x00,0x7F; without the macro, raw values.
